// File: rtl/instr_sequencer_if.sv
// Instruction-memory fetch handshake between the sequencer (master) and the memory (slave).
interface instr_sequencer_if;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer with registered control outputs.
// Define SEQ_SINGLE_STEP_EN to add the step input and a PAUSE state after each writeback.
module instr_sequencer (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     run,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic                     step,
`endif
  instr_sequencer_if.master        imem,
  output logic [5:0]               opcode,
  input  logic                     cu_alu_enable,
  input  logic                     cu_reg_write,
  output logic                     alu_en,
  output logic                     reg_write_en,
  output logic [7:0]               pc,
  output logic                     busy,
  output logic                     halted
);

  localparam logic [5:0] HaltOp = 6'b111111;

`ifdef SEQ_SINGLE_STEP_EN
  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StExecute, StWriteback, StHalt, StPause
  } state_e;
`else
  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StExecute, StWriteback, StHalt
  } state_e;
`endif

  state_e      state_q;
  logic [7:0]  pc_q;
  logic [15:0] ir_q;
  logic        req_q;
  logic        alu_q;
  logic        rw_q;
  logic        busy_q;
  logic        halted_q;

  assign opcode         = ir_q[15:10];
  assign pc             = pc_q;
  assign imem.imem_addr = pc_q;
  assign imem.imem_req  = req_q;
  assign alu_en         = alu_q;
  assign reg_write_en   = rw_q;
  assign busy           = busy_q;
  assign halted         = halted_q;

  // Outputs are registered alongside the state, so each one is set on the edge that
  // enters the state in which it must be visible.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      pc_q     <= 8'd0;
      ir_q     <= 16'd0;
      req_q    <= 1'b0;
      alu_q    <= 1'b0;
      rw_q     <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      alu_q <= 1'b0;
      rw_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (run) begin
            state_q <= StFetch;
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        StFetch: begin
          if (imem.imem_ack) begin
            ir_q    <= imem.imem_rdata;
            req_q   <= 1'b0;
            state_q <= StDecode;
          end
        end
        StDecode: begin
          // The control unit decodes opcode combinationally; its outputs settle here.
          if (ir_q[15:10] == HaltOp) begin
            state_q  <= StHalt;
            busy_q   <= 1'b0;
            halted_q <= 1'b1;
          end else begin
            state_q <= StExecute;
            alu_q   <= cu_alu_enable;
          end
        end
        StExecute: begin
          state_q <= StWriteback;
          rw_q    <= cu_reg_write;
        end
        StWriteback: begin
          pc_q <= pc_q + 8'd1;
`ifdef SEQ_SINGLE_STEP_EN
          state_q <= StPause;
`else
          state_q <= StFetch;
          req_q   <= 1'b1;
`endif
        end
`ifdef SEQ_SINGLE_STEP_EN
        StPause: begin
          if (step) begin
            state_q <= StFetch;
            req_q   <= 1'b1;
          end
        end
`endif
        StHalt: begin
          state_q <= StHalt;
        end
        default: begin
          state_q  <= StIdle;
          req_q    <= 1'b0;
          busy_q   <= 1'b0;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: instruction-level reference model, random stimulus.
module tb_instr_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic [5:0] opcode;
  logic       cu_alu_enable;
  logic       cu_reg_write;
  logic       alu_en;
  logic       reg_write_en;
  logic [7:0] pc;
  logic       busy;
  logic       halted;
`ifdef SEQ_SINGLE_STEP_EN
  logic       step = 1'b0;
  int         pause_len = 1;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int exp_pc = 0;

  instr_sequencer_if imem ();

  instr_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .run           (run),
`ifdef SEQ_SINGLE_STEP_EN
    .step          (step),
`endif
    .imem          (imem.master),
    .opcode        (opcode),
    .cu_alu_enable (cu_alu_enable),
    .cu_reg_write  (cu_reg_write),
    .alu_en        (alu_en),
    .reg_write_en  (reg_write_en),
    .pc            (pc),
    .busy          (busy),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  // Toy control unit: opcode bit 0 requests the ALU, bit 1 requests a register write.
  assign cu_alu_enable = opcode[0];
  assign cu_reg_write  = opcode[1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) chk("excl", {31'd0, alu_en & reg_write_en}, 32'd0);

  task automatic chk_reset_state();
    chk("rst_req", {31'd0, imem.imem_req}, 32'd0);
    chk("rst_pc", {24'd0, pc}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_alu", {31'd0, alu_en}, 32'd0);
    chk("rst_rw", {31'd0, reg_write_en}, 32'd0);
    chk("rst_opcode", {26'd0, opcode}, 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run = 1'b0;
    imem.imem_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_pc = 0;
    chk_reset_state();
  endtask

  task automatic start_run();
    run = 1'b1;
    @(negedge clk);
    run = 1'($urandom);
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    w = 16'($urandom);
    while (w[15:10] == 6'h3F) w = 16'($urandom);
    return w;
  endfunction

  // Entered at the first FETCH cycle; leaves at the next FETCH (or in HALT).
  task automatic run_instr(input logic [15:0] word, input int delay);
    logic [5:0] op;
    op = word[15:10];
    for (int k = 0; k <= delay; k++) begin
      chk("fetch_req", {31'd0, imem.imem_req}, 32'd1);
      chk("fetch_addr", {24'd0, imem.imem_addr}, 32'(exp_pc));
      chk("fetch_busy", {31'd0, busy}, 32'd1);
      chk("fetch_alu", {31'd0, alu_en}, 32'd0);
      imem.imem_ack = (k == delay);
      imem.imem_rdata = (k == delay) ? word : 16'($urandom);
      run = 1'($urandom);
      @(negedge clk);
    end
    imem.imem_ack = 1'($urandom);
    imem.imem_rdata = 16'($urandom);
    chk("dec_req", {31'd0, imem.imem_req}, 32'd0);
    chk("dec_opcode", {26'd0, opcode}, {26'd0, op});
    chk("dec_busy", {31'd0, busy}, 32'd1);
    chk("dec_alu", {31'd0, alu_en}, 32'd0);
    chk("dec_rw", {31'd0, reg_write_en}, 32'd0);
    @(negedge clk);
    if (op == 6'h3F) begin
      imem.imem_ack = 1'b0;
      chk("halt_halted", {31'd0, halted}, 32'd1);
      chk("halt_busy", {31'd0, busy}, 32'd0);
      chk("halt_pc", {24'd0, pc}, 32'(exp_pc));
      return;
    end
    imem.imem_ack = 1'($urandom);
    chk("exe_alu", {31'd0, alu_en}, {31'd0, op[0]});
    chk("exe_rw", {31'd0, reg_write_en}, 32'd0);
    chk("exe_req", {31'd0, imem.imem_req}, 32'd0);
    @(negedge clk);
    imem.imem_ack = 1'($urandom);
    chk("wb_rw", {31'd0, reg_write_en}, {31'd0, op[1]});
    chk("wb_alu", {31'd0, alu_en}, 32'd0);
    chk("wb_pc", {24'd0, pc}, 32'(exp_pc));
    @(negedge clk);
    imem.imem_ack = 1'b0;
    exp_pc = (exp_pc + 1) % 256;
`ifdef SEQ_SINGLE_STEP_EN
    for (int k = 0; k < pause_len; k++) begin
      chk("pause_busy", {31'd0, busy}, 32'd1);
      chk("pause_req", {31'd0, imem.imem_req}, 32'd0);
      chk("pause_pc", {24'd0, pc}, 32'(exp_pc));
      imem.imem_ack = 1'($urandom);
      @(negedge clk);
    end
    imem.imem_ack = 1'b0;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
`endif
  endtask

  initial begin
    imem.imem_ack = 1'b0;
    imem.imem_rdata = 16'd0;
    @(negedge clk);
    do_reset();

    // Idle holds with run low.
    repeat (3) @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_req", {31'd0, imem.imem_req}, 32'd0);

    // LDIM with immediate ack, then a slow fetch.
    start_run();
    run_instr(16'h3800, 0);
    chk("ldim_pc", {24'd0, pc}, 32'd1);
    run_instr(rand_word(), 3);

    for (int i = 0; i < 20; i++) run_instr(rand_word(), int'($urandom_range(0, 3)));

    // Reset while a fetch is outstanding; a late ack must be ignored.
    chk("mid_req", {31'd0, imem.imem_req}, 32'd1);
    rst_n = 1'b0;
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    imem.imem_ack = 1'b1;
    imem.imem_rdata = 16'hFFFF;
    exp_pc = 0;
    chk_reset_state();
    @(negedge clk);
    chk("late_ack_busy", {31'd0, busy}, 32'd0);
    chk("late_ack_req", {31'd0, imem.imem_req}, 32'd0);
    chk("late_ack_opcode", {26'd0, opcode}, 32'd0);
    imem.imem_ack = 1'b0;

    // PC wrap: 255 instructions bring pc to 255, then a NOP wraps it.
    start_run();
    for (int i = 0; i < 255; i++) run_instr(rand_word(), 0);
    chk("pre_wrap_pc", {24'd0, pc}, 32'd255);
    run_instr(16'h0000, 0);
    chk("wrap_pc", {24'd0, pc}, 32'd0);

    // Halt at a nonzero pc is sticky against run and ack.
    for (int i = 0; i < 3; i++) run_instr(rand_word(), int'($urandom_range(0, 2)));
    run_instr(16'hFC00, 1);
    for (int i = 0; i < 10; i++) begin
      run = 1'($urandom);
      imem.imem_ack = 1'($urandom);
      imem.imem_rdata = 16'($urandom);
      @(negedge clk);
      chk("halt_sticky", {31'd0, halted}, 32'd1);
      chk("halt_pc_hold", {24'd0, pc}, 32'd3);
      chk("halt_req", {31'd0, imem.imem_req}, 32'd0);
      chk("halt_idle_busy", {31'd0, busy}, 32'd0);
    end
    do_reset();

`ifdef SEQ_SINGLE_STEP_EN
    start_run();
    pause_len = 10;
    run_instr(rand_word(), 0);
    pause_len = 1;
    run_instr(rand_word(), 2);
    chk("step_pc", {24'd0, pc}, 32'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
